// File: rtl/data_ram_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the interface, the BRAM and the responder top.
package data_ram_resp_pkg;

  localparam int RegBus         = 32;
  localparam int DataMemNumLog2 = 17;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/data_ram_resp_if.sv
// MEM-stage <-> data-memory bus.
// master = MEM stage, slave = memory responder.
interface data_ram_resp_if;
  import data_ram_resp_pkg::*;

  logic              ce_i;
  logic              we_i;
  logic [31:0]       addr_i;
  logic [3:0]        sel_i;
  logic [RegBus-1:0] data_i;
  logic [RegBus-1:0] data_o;
  logic              stallreq_o;
  logic              addr_err_o;

  modport master (
    output ce_i,
    output we_i,
    output addr_i,
    output sel_i,
    output data_i,
    input  data_o,
    input  stallreq_o,
    input  addr_err_o
  );

  modport slave (
    input  ce_i,
    input  we_i,
    input  addr_i,
    input  sel_i,
    input  data_i,
    output data_o,
    output stallreq_o,
    output addr_err_o
  );

endinterface

// File: rtl/data_ram_resp_data_bram.sv
// Single-port byte-lane-writable data BRAM.
// Sync read plus LAT-1 output register stages; array not reset.
module data_bram
  import data_ram_resp_pkg::*;
#(
  parameter int AW  = DataMemNumLog2,
  parameter int LAT = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        sel,
  input  logic [AW-1:0]     addr,
  input  logic [RegBus-1:0] wdata,
  input  logic              re,
  output logic [RegBus-1:0] rdata
);

  logic [RegBus-1:0] mem_q  [0:(1<<AW)-1];
  logic [RegBus-1:0] pipe_q [0:LAT-1];

  // Byte-lane write, registered read, then latency pipeline
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) pipe_q[0] <= mem_q[addr];
    for (int k = 1; k < LAT; k++) begin
      pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign rdata = pipe_q[LAT-1];

endmodule

// File: rtl/data_ram_resp.sv
// MEM-stage data-memory responder: one-cycle stores,
// stalled loads over a fixed-latency BRAM, range check.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_W       = DataMemNumLog2,
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  data_ram_resp_if.slave bus
);

  localparam logic [1:0] CntInit = 2'(READ_LATENCY - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [RegBus-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic              in_range;
  logic              access;
  logic              st_go;
  logic              ld_go;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] bram_addr;
  logic [RegBus-1:0] bram_rdata;
  logic              unused_lsb;

  assign unused_lsb = ^bus.addr_i[1:0];

  assign widx     = bus.addr_i[ADDR_W+1:2];
  assign in_range = (bus.addr_i[31:ADDR_W+2] == '0);
  assign access   = (state_q == IDLE) && (bus.ce_i == ChipEnable) && !rst;
  assign st_go    = access && in_range && (bus.we_i == WriteEnable);
  assign ld_go    = access && in_range && (bus.we_i == WriteDisable);

  assign bram_addr = (state_q == IDLE) ? widx : idx_q;

  data_bram #(
    .AW  (ADDR_W),
    .LAT (READ_LATENCY)
  ) u_bram (
    .clk   (clk),
    .we    (st_go),
    .sel   (bus.sel_i),
    .addr  (bram_addr),
    .wdata (bus.data_i),
    .re    (ld_go),
    .rdata (bram_rdata)
  );

  // Next-state: issue loads, count down latency, capture word
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    err_d   = access && !in_range;
    unique case (state_q)
      IDLE: begin
        if (ld_go) begin
          state_d = RD_WAIT;
          cnt_d   = CntInit;
          idx_d   = widx;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          data_d  = bram_rdata;
          state_d = RD_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      data_q  <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  // Stall covers the issue cycle combinationally
  assign bus.stallreq_o = ld_go || (state_q == RD_WAIT);
  assign bus.data_o     = data_q;
  assign bus.addr_err_o = err_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed self-checking bench for data_ram_resp.
// Main DUT at latency 2, plus latency-1 and latency-4 DUTs.
module tb_data_ram_resp;
  import data_ram_resp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  data_ram_resp_if b ();
  data_ram_resp_if s1 ();
  data_ram_resp_if s4 ();

  data_ram_resp #(.READ_LATENCY(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  data_ram_resp #(.READ_LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (s1)
  );

  data_ram_resp #(.READ_LATENCY(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (s4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    b.ce_i   = 1'b0;
    b.we_i   = 1'b0;
    b.addr_i = '0;
    b.sel_i  = '0;
    b.data_i = '0;
  endtask

  task automatic sweep_drive(input logic ce, input logic we,
                             input logic [31:0] a,
                             input logic [31:0] d);
    s1.ce_i = ce; s1.we_i = we; s1.addr_i = a;
    s1.sel_i = 4'hF; s1.data_i = d;
    s4.ce_i = ce; s4.we_i = we; s4.addr_i = a;
    s4.sel_i = 4'hF; s4.data_i = d;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    b.ce_i   = 1'b1;
    b.we_i   = 1'b1;
    b.addr_i = a;
    b.sel_i  = s;
    b.data_i = d;
    cyc();
    idle_bus();
  endtask

  task automatic load(input logic [31:0] a, output int n,
                      output logic [31:0] d);
    b.ce_i   = 1'b1;
    b.we_i   = 1'b0;
    b.addr_i = a;
    b.sel_i  = 4'hF;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b.stallreq_o !== 1'b1) break;
      n++;
    end
    d = b.data_o;
    cyc();
    idle_bus();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    sweep_drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (b.data_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_data got %h want %h", b.data_o, 32'h0);
    end
    tests++;
    if (b.stallreq_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_stall got %b want 0", b.stallreq_o);
    end
    tests++;
    if (b.addr_err_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_err got %b want 0", b.addr_err_o);
    end
    cyc();
  endtask

  task automatic test_store_load();
    int n;
    logic [31:0] d;
    store(32'h10, 4'hF, 32'hDEADBEEF);
    load(32'h10, n, d);
    tests++;
    if (n !== 3) begin
      fails++;
      $display("FAIL st_ld_stall got %0d want 3", n);
    end
    tests++;
    if (d !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL st_ld_data got %h want DEADBEEF", d);
    end
  endtask

  task automatic test_byte_merge();
    int n;
    logic [31:0] d;
    store(32'h10, 4'b0100, 32'h55555555);
    load(32'h10, n, d);
    tests++;
    if (n !== 3) begin
      fails++;
      $display("FAIL merge_stall got %0d want 3", n);
    end
    tests++;
    if (d !== 32'hDE55BEEF) begin
      fails++;
      $display("FAIL merge_data got %h want DE55BEEF", d);
    end
  endtask

  task automatic test_out_of_range();
    int n;
    logic [31:0] d;
    store(32'h0, 4'hF, 32'hA5A5A5A5);
    load(32'h0, n, d);
    b.ce_i   = 1'b1;
    b.we_i   = 1'b0;
    b.addr_i = 32'h0008_0000;
    @(negedge clk);
    tests++;
    if (b.stallreq_o !== 1'b0) begin
      fails++;
      $display("FAIL oob_stall got %b want 0", b.stallreq_o);
    end
    tests++;
    if (b.addr_err_o !== 1'b0) begin
      fails++;
      $display("FAIL oob_err_early got %b want 0", b.addr_err_o);
    end
    cyc();
    idle_bus();
    @(negedge clk);
    tests++;
    if (b.addr_err_o !== 1'b1) begin
      fails++;
      $display("FAIL oob_err_pulse got %b want 1", b.addr_err_o);
    end
    tests++;
    if (b.data_o !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL oob_data got %h want A5A5A5A5", b.data_o);
    end
    cyc();
    @(negedge clk);
    tests++;
    if (b.addr_err_o !== 1'b0) begin
      fails++;
      $display("FAIL oob_err_len got %b want 0", b.addr_err_o);
    end
    cyc();
    store(32'h0008_0000, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    tests++;
    if (b.addr_err_o !== 1'b1) begin
      fails++;
      $display("FAIL oob_st_err got %b want 1", b.addr_err_o);
    end
    cyc();
    load(32'h0, n, d);
    tests++;
    if (d !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL oob_st_w0 got %h want A5A5A5A5", d);
    end
    load(32'h10, n, d);
    tests++;
    if (d !== 32'hDE55BEEF) begin
      fails++;
      $display("FAIL oob_st_w4 got %h want DE55BEEF", d);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    logic [31:0] d1, d2;
    store(32'h10, 4'hF, 32'h11111111);
    store(32'h14, 4'hF, 32'h22222222);
    load(32'h10, n1, d1);
    load(32'h14, n2, d2);
    tests++;
    if (n1 !== 3 || n2 !== 3) begin
      fails++;
      $display("FAIL b2b_stall got %0d/%0d want 3/3", n1, n2);
    end
    tests++;
    if (d1 !== 32'h11111111) begin
      fails++;
      $display("FAIL b2b_data1 got %h want 11111111", d1);
    end
    tests++;
    if (d2 !== 32'h22222222) begin
      fails++;
      $display("FAIL b2b_data2 got %h want 22222222", d2);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    logic [31:0] d;
    store(32'h10, 4'hF, 32'hDEADBEEF);
    b.ce_i   = 1'b1;
    b.we_i   = 1'b0;
    b.addr_i = 32'h10;
    cyc();
    cyc();
    rst = 1'b1;
    idle_bus();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (b.stallreq_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_stall got %b want 0", b.stallreq_o);
    end
    tests++;
    if (b.data_o !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_data got %h want 0", b.data_o);
    end
    cyc();
    load(32'h10, n, d);
    tests++;
    if (n !== 3 || d !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rst_reload got %0d/%h want 3/DEADBEEF", n, d);
    end
  endtask

  task automatic test_latency_sweep();
    int n1, n4;
    bit dn1, dn4;
    logic [31:0] d1, d4;
    n1 = 0; n4 = 0; dn1 = 0; dn4 = 0;
    d1 = '0; d4 = '0;
    sweep_drive(1'b1, 1'b1, 32'h40, 32'hCAFEF00D);
    cyc();
    sweep_drive(1'b1, 1'b0, 32'h40, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!dn1) begin
        if (s1.stallreq_o === 1'b1) n1++;
        else begin dn1 = 1; d1 = s1.data_o; end
      end
      if (!dn4) begin
        if (s4.stallreq_o === 1'b1) n4++;
        else begin dn4 = 1; d4 = s4.data_o; end
      end
      cyc();
      if (c == 0) sweep_drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
    tests++;
    if (n1 !== 2) begin
      fails++;
      $display("FAIL lat1_stall got %0d want 2", n1);
    end
    tests++;
    if (d1 !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL lat1_data got %h want CAFEF00D", d1);
    end
    tests++;
    if (n4 !== 5) begin
      fails++;
      $display("FAIL lat4_stall got %0d want 5", n4);
    end
    tests++;
    if (d4 !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL lat4_data got %h want CAFEF00D", d4);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_merge();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_read();
    test_latency_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
